// File: rtl/servo_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : servo_ramp_ctrl
//  Description : Frame-synchronous duty-cycle sequencer for a servo PWM core.
//                It accepts absolute position commands, slews the duty toward
//                them by at most STEP per frame, and runs an autonomous
//                MIN<->MAX sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module servo_ramp_ctrl #(
  parameter int W             = 20,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int DUTY_MIN      = 25_000,
  parameter int DUTY_MAX      = 125_000,
  parameter int STEP          = 5_000
) (
  input  logic         clk,
  input  logic         rst_a_p,
  input  logic         cmd_valid,
  input  logic [W-1:0] cmd_target,
  output logic         cmd_ready,
  input  logic         sweep_en,
  output logic [W-1:0] duty_cycle,
  output logic         frame_tick,
  output logic         busy,
  output logic         at_target
);

  // Constants used in the arithmetic are one bit wider than the duty word,
  // so that duty+STEP cannot wrap before it is saturated.
  localparam logic [W-1:0] c_frame_last = W'(PERIOD_CYCLES - 1);
  localparam logic [W:0]   c_duty_min   = (W+1)'(DUTY_MIN);
  localparam logic [W:0]   c_duty_max   = (W+1)'(DUTY_MAX);
  localparam logic [W:0]   c_step       = (W+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RAMP       = 2'd1,
    SWEEP_UP   = 2'd2,
    SWEEP_DOWN = 2'd3
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_frame_cnt;
  logic [W-1:0] r_duty;
  logic [W-1:0] r_target;

  logic         w_accept;
  logic [W:0]   w_duty_x;
  logic [W-1:0] w_clamped;
  logic [W-1:0] w_new_target;
  logic [W-1:0] w_ramp_step;
  logic [W-1:0] w_ramp_next;
  logic [W-1:0] w_up_step;
  logic [W-1:0] w_down_step;

  // Move d toward t by at most STEP, landing exactly on t rather than
  // overshooting it. Both subtraction and addition stay in W+1 bits.
  function automatic logic [W-1:0] f_step_toward(input logic [W:0] d,
                                                 input logic [W:0] t);
    logic [W:0] v_sum;
    logic [W:0] v_diff;
    v_sum  = d + c_step;
    v_diff = d - c_step;
    if (d < t) begin
      return (v_sum >= t) ? t[W-1:0] : v_sum[W-1:0];
    end else if (d > t + c_step) begin
      return v_diff[W-1:0];
    end else begin
      return t[W-1:0];
    end
  endfunction

  // Commands are refused entirely while the sweep owns the duty.
  assign cmd_ready  = ~sweep_en;
  assign w_accept   = cmd_valid & cmd_ready;
  assign frame_tick = (r_frame_cnt == c_frame_last);
  assign duty_cycle = r_duty;
  assign busy       = (r_state != IDLE);
  assign at_target  = (r_state == IDLE) && (r_duty == r_target);
  assign w_duty_x   = {1'b0, r_duty};

  // Clamp the incoming command and pick the target the ramp should chase
  // this cycle, so a command landing on a tick edge steps toward itself.
  always_comb begin
    w_clamped = cmd_target;
    if ({1'b0, cmd_target} < c_duty_min) begin
      w_clamped = c_duty_min[W-1:0];
    end else if ({1'b0, cmd_target} > c_duty_max) begin
      w_clamped = c_duty_max[W-1:0];
    end
    w_new_target = w_accept ? w_clamped : r_target;
    w_ramp_step  = f_step_toward(w_duty_x, {1'b0, w_new_target});
    w_ramp_next  = frame_tick ? w_ramp_step : r_duty;
    w_up_step    = f_step_toward(w_duty_x, c_duty_max);
    w_down_step  = f_step_toward(w_duty_x, c_duty_min);
  end

  // Free-running frame counter; wraps on the last cycle of each frame.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      r_frame_cnt <= '0;
    end else if (frame_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Sequencer: duty only ever changes on a frame_tick edge.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      r_state  <= IDLE;
      r_duty   <= c_duty_min[W-1:0];
      r_target <= c_duty_min[W-1:0];
    end else if (!sweep_en) begin
      // Command/ramp path, also used to leave either sweep state.
      r_target <= w_new_target;
      r_duty   <= w_ramp_next;
      r_state  <= (w_ramp_next == w_new_target) ? IDLE : RAMP;
    end else begin
      case (r_state)
        IDLE, RAMP: begin
          r_state <= SWEEP_UP;
        end
        SWEEP_UP: begin
          if (frame_tick) begin
            r_duty <= w_up_step;
            if ({1'b0, w_up_step} == c_duty_max) begin
              r_state <= SWEEP_DOWN;
            end
          end
        end
        SWEEP_DOWN: begin
          if (frame_tick) begin
            r_duty <= w_down_step;
            if ({1'b0, w_down_step} == c_duty_min) begin
              r_state <= SWEEP_UP;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_ramp_ctrl
//  Description : Self-checking bench for servo_ramp_ctrl with a small frame
//                (100 cycles) and duty range 10..50, step 5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_ramp_ctrl;

  localparam int W   = 20;
  localparam int PER = 100;

  logic         clk;
  logic         rst_a_p;
  logic         cmd_valid;
  logic [W-1:0] cmd_target;
  logic         cmd_ready;
  logic         sweep_en;
  logic [W-1:0] duty_cycle;
  logic         frame_tick;
  logic         busy;
  logic         at_target;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected duty after each successive frame tick.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  servo_ramp_ctrl #(
    .W(W), .PERIOD_CYCLES(PER), .DUTY_MIN(10), .DUTY_MAX(50), .STEP(5)
  ) dut (
    .clk(clk), .rst_a_p(rst_a_p), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .sweep_en(sweep_en), .duty_cycle(duty_cycle),
    .frame_tick(frame_tick), .busy(busy), .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  // Return 1 ns after the next edge on which frame_tick is sampled high.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles, required one", 3 * PER);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int t);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = W'(t);
    @(posedge clk);
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Count posedges after release until frame_tick is visible.
  task automatic measure_tick_gap(input string name, input int expected);
    int n;
    n = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (frame_tick) break;
    end
    n_tests++;
    if (n !== expected) begin
      n_fail++;
      $display("FAIL %s: cycles to frame_tick %0d, required %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (duty_cycle !== 10 || busy !== 1'b0 || at_target !== 1'b1 ||
        frame_tick !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: duty=%0d busy=%b at=%b tick=%b rdy=%b, required 10 0 1 0 1",
               duty_cycle, busy, at_target, frame_tick, cmd_ready);
    end
    @(negedge clk);
    rst_a_p = 1'b0;
    measure_tick_gap("first_tick_after_reset", PER - 1);
    measure_tick_gap("tick_period", PER);
    // Reset in the middle of a ramp and in the middle of a frame.
    wait_tick();
    send_cmd(40);
    wait_tick();
    n_tests++;
    if (duty_cycle !== 15) begin
      n_fail++;
      $display("FAIL pre_reset_ramp: duty=%0d, required 15", duty_cycle);
    end
    repeat (30) @(negedge clk);
    #2 rst_a_p = 1'b1;
    #1;
    n_tests++;
    if (duty_cycle !== 10 || busy !== 1'b0 || at_target !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: duty=%0d busy=%b at=%b tick=%b, required 10 0 1 0",
               duty_cycle, busy, at_target, frame_tick);
    end
    @(negedge clk);
    rst_a_p = 1'b0;
    measure_tick_gap("tick_after_midframe_reset", PER - 1);
  endtask

  task automatic test_ramp_up();
    wait_tick();
    send_cmd(32);
    n_tests++;
    if (busy !== 1'b1 || at_target !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_start: busy=%b at=%b, required 1 0", busy, at_target);
    end
    for (int v = 15; v <= 30; v += 5) exp_q.push_back(W'(v));
    exp_q.push_back(W'(32));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL ramp_up_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_up_done: busy=%b at=%b, required 0 1", busy, at_target);
    end
  endtask

  task automatic test_clamp_override();
    send_cmd(200);
    exp_q.push_back(W'(37));
    exp_q.push_back(W'(42));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL clamp_high_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    send_cmd(3);
    for (int v = 37; v >= 12; v -= 5) exp_q.push_back(W'(v));
    exp_q.push_back(W'(10));
    exp_q.push_back(W'(10));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL override_down_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL override_done: busy=%b at=%b, required 0 1", busy, at_target);
    end
  endtask

  task automatic test_sweep();
    @(negedge clk);
    sweep_en   = 1'b1;
    cmd_valid  = 1'b1;
    cmd_target = W'(40);
    #1;
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    for (int v = 15; v <= 50; v += 5) exp_q.push_back(W'(v));
    for (int v = 45; v >= 10; v -= 5) exp_q.push_back(W'(v));
    exp_q.push_back(W'(15));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_step: duty=%0d busy=%b, required %0d 1", duty_cycle, busy, exp_v);
      end
    end
    // The refused command must not have moved the target off 10.
    @(negedge clk);
    sweep_en  = 1'b0;
    cmd_valid = 1'b0;
    exp_q.push_back(W'(10));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v || at_target !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_ignored_cmd: duty=%0d at=%b, required %0d 1", duty_cycle, at_target, exp_v);
      end
    end
  endtask

  task automatic test_sweep_exit();
    send_cmd(20);
    exp_q.push_back(W'(15));
    exp_q.push_back(W'(20));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL exit_setup_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    @(negedge clk);
    sweep_en = 1'b1;
    for (int v = 25; v <= 35; v += 5) exp_q.push_back(W'(v));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL exit_sweep_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    @(negedge clk);
    sweep_en = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || at_target !== 1'b0 || duty_cycle !== 35) begin
      n_fail++;
      $display("FAIL exit_to_ramp: busy=%b at=%b duty=%0d, required 1 0 35", busy, at_target, duty_cycle);
    end
    for (int v = 30; v >= 20; v -= 5) exp_q.push_back(W'(v));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL exit_ramp_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_done: busy=%b at=%b, required 0 1", busy, at_target);
    end
  endtask

  task automatic test_tick_collision();
    bit seen;
    send_cmd(10);
    exp_q.push_back(W'(15));
    exp_q.push_back(W'(10));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL collision_setup_step: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
    // Present the command in the cycle where frame_tick is high.
    seen = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL collision_tick_timeout: frame_tick=0, required 1");
    end
    cmd_valid  = 1'b1;
    cmd_target = W'(12);
    exp_q.push_back(W'(12));
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (duty_cycle !== exp_v || busy !== 1'b0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_collision: duty=%0d busy=%b at=%b, required %0d 0 1",
               duty_cycle, busy, at_target, exp_v);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back(W'(12));
    while (exp_q.size() != 0) begin
      wait_tick();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (duty_cycle !== exp_v) begin
        n_fail++;
        $display("FAIL collision_hold: duty=%0d, required %0d", duty_cycle, exp_v);
      end
    end
  endtask

  initial begin
    rst_a_p    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    sweep_en   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ramp_up();
    test_clamp_override();
    test_sweep();
    test_sweep_exit();
    test_tick_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
